// File: rtl/psg_register_decoder.sv
// Decodes the sound-chip write byte stream into tone, noise and attenuation registers.
// Define PSG_READY_EN to add the ready/busy handshake; otherwise every write is accepted.
module psg_register_decoder #(
    parameter int unsigned BUSY_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_div16_en,
    input  logic       we,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] tone0_freq,
    output logic [9:0] tone1_freq,
    output logic [9:0] tone2_freq,
    output logic [2:0] noise_ctrl,
    output logic [3:0] atten0,
    output logic [3:0] atten1,
    output logic [3:0] atten2,
    output logic [3:0] atten3,
    output logic       noise_reset
);

    logic       accept;
    logic [1:0] tgt_ch;
    logic       tgt_type;

    logic [1:0] latch_ch_q, latch_ch_d;
    logic       latch_type_q, latch_type_d;
    logic [9:0] tone_q [3];
    logic [9:0] tone_d [3];
    logic [3:0] atten_q [4];
    logic [3:0] atten_d [4];
    logic [2:0] noise_q, noise_d;
    logic       noise_reset_q, noise_reset_d;

    assign accept = we & ready;

`ifdef PSG_READY_EN
    localparam logic [3:0] BusyTicks = 4'(BUSY_TICKS);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // The tick on the accepting edge is not counted: the counter is loaded, not decremented.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (we && (BUSY_TICKS != 0)) begin
                    state_d = StBusy;
                    cnt_d   = BusyTicks;
                end
            end
            StBusy: begin
                if (clk_div16_en) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == StIdle);
`else
    localparam int unsigned UnusedBusyTicks = BUSY_TICKS;

    logic unused_div_en;
    assign unused_div_en = clk_div16_en;
    assign ready         = 1'b1;
`endif

    // Latch bytes carry their own target; data bytes reuse the last latched one.
    always_comb begin
        latch_ch_d    = latch_ch_q;
        latch_type_d  = latch_type_q;
        tone_d        = tone_q;
        atten_d       = atten_q;
        noise_d       = noise_q;
        noise_reset_d = 1'b0;
        tgt_ch        = din[7] ? din[6:5] : latch_ch_q;
        tgt_type      = din[7] ? din[4]   : latch_type_q;

        if (accept) begin
            if (din[7]) begin
                latch_ch_d   = din[6:5];
                latch_type_d = din[4];
            end
            if (tgt_type) begin
                atten_d[tgt_ch] = din[3:0];
            end else if (tgt_ch == 2'd3) begin
                noise_d       = din[2:0];
                noise_reset_d = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (tgt_ch == 2'(i)) begin
                        if (din[7]) begin
                            tone_d[i][3:0] = din[3:0];
                        end else begin
                            tone_d[i][9:4] = din[5:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            latch_ch_q    <= 2'd0;
            latch_type_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tone_q[i] <= 10'd0;
            end
            for (int i = 0; i < 4; i++) begin
                atten_q[i] <= 4'hF;
            end
            noise_q       <= 3'd0;
            noise_reset_q <= 1'b0;
        end else begin
            latch_ch_q    <= latch_ch_d;
            latch_type_q  <= latch_type_d;
            tone_q        <= tone_d;
            atten_q       <= atten_d;
            noise_q       <= noise_d;
            noise_reset_q <= noise_reset_d;
        end
    end

    assign tone0_freq  = tone_q[0];
    assign tone1_freq  = tone_q[1];
    assign tone2_freq  = tone_q[2];
    assign atten0      = atten_q[0];
    assign atten1      = atten_q[1];
    assign atten2      = atten_q[2];
    assign atten3      = atten_q[3];
    assign noise_ctrl  = noise_q;
    assign noise_reset = noise_reset_q;

endmodule

// File: tb/tb_psg_register_decoder.sv
// Bench for psg_register_decoder: directed table, busy/reset corner sequences, random vs model.
module tb_psg_register_decoder;

    localparam int unsigned Busy = 2;
`ifdef PSG_READY_EN
    localparam bit ReadyEn = 1'b1;
`else
    localparam bit ReadyEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_div16_en = 1'b0;
    logic       we = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready;
    logic [9:0] tone0_freq, tone1_freq, tone2_freq;
    logic [2:0] noise_ctrl;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic       noise_reset;

    psg_register_decoder #(.BUSY_TICKS(Busy)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_div16_en (clk_div16_en),
        .we           (we),
        .din          (din),
        .ready        (ready),
        .tone0_freq   (tone0_freq),
        .tone1_freq   (tone1_freq),
        .tone2_freq   (tone2_freq),
        .noise_ctrl   (noise_ctrl),
        .atten0       (atten0),
        .atten1       (atten1),
        .atten2       (atten2),
        .atten3       (atten3),
        .noise_reset  (noise_reset)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain register file plus "ticks remaining" before the next write.
    int m_tone [3];
    int m_att [4];
    int m_noise, m_nr, m_ch, m_type, busy_left;

    function automatic bit m_ready();
        return ReadyEn ? (busy_left == 0) : 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit w, input logic [7:0] d, input bit e);
        bit acc;
        if (!r) begin
            foreach (m_tone[i]) m_tone[i] = 0;
            foreach (m_att[i]) m_att[i] = 15;
            m_noise = 0; m_nr = 0; m_ch = 0; m_type = 0; busy_left = 0;
            return;
        end
        acc  = w && m_ready();
        m_nr = 0;
        if (ReadyEn) begin
            if (busy_left > 0 && e) busy_left--;
            if (acc) busy_left = Busy;
        end
        if (!acc) return;
        if (d[7]) begin
            m_ch   = int'(d[6:5]);
            m_type = int'(d[4]);
        end
        if (m_type == 1) m_att[m_ch] = int'(d[3:0]);
        else if (m_ch == 3) begin
            m_noise = int'(d[2:0]);
            m_nr    = 1;
        end else if (d[7]) m_tone[m_ch] = (m_tone[m_ch] & 'h3F0) + int'(d[3:0]);
        else m_tone[m_ch] = (m_tone[m_ch] & 'h00F) + int'(d[5:0]) * 16;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("ready", 32'(ready), 32'(m_ready()));
        check("tone0", 32'(tone0_freq), m_tone[0]);
        check("tone1", 32'(tone1_freq), m_tone[1]);
        check("tone2", 32'(tone2_freq), m_tone[2]);
        check("atten0", 32'(atten0), m_att[0]);
        check("atten1", 32'(atten1), m_att[1]);
        check("atten2", 32'(atten2), m_att[2]);
        check("atten3", 32'(atten3), m_att[3]);
        check("noise_ctrl", 32'(noise_ctrl), m_noise);
        check("noise_reset", 32'(noise_reset), m_nr);
    endtask

    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit e);
        reset = r; we = w; din = d; clk_div16_en = e;
        model_edge(r, w, d, e);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready() && n < 64) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            n++;
        end
        if (!m_ready()) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    typedef enum int {CkNone, CkReady, CkTone0, CkTone1, CkTone2, CkAtten0, CkAtten1,
                      CkNoise, CkNr} ck_e;

    typedef struct {
        bit         wr;
        bit         r;
        bit         w;
        logic [7:0] d;
        bit         e;
        ck_e        ca;
        int         ea;
        ck_e        cb;
        int         eb;
    } vec_t;

    function automatic vec_t mk(bit wr, bit r, bit w, logic [7:0] d, bit e,
                                ck_e ca, int ea, ck_e cb, int eb);
        vec_t v;
        v.wr = wr; v.r = r; v.w = w; v.d = d; v.e = e;
        v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
        return v;
    endfunction

    function automatic logic [31:0] pick(ck_e c);
        case (c)
            CkReady:  return 32'(ready);
            CkTone0:  return 32'(tone0_freq);
            CkTone1:  return 32'(tone1_freq);
            CkTone2:  return 32'(tone2_freq);
            CkAtten0: return 32'(atten0);
            CkAtten1: return 32'(atten1);
            CkNoise:  return 32'(noise_ctrl);
            CkNr:     return 32'(noise_reset);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_fixed(input int idx, input ck_e c, input int exp);
        string nm;
        nm = $sformatf("vec%0d_%s", idx, c.name());
        check(nm, pick(c), 32'(exp));
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, CkTone0, 0, CkAtten0, 15));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, CkReady, 1, CkNoise, 0));
        tbl.push_back(mk(1, 1, 1, 8'h8E, 0, CkTone0, 'h00E, CkAtten0, 15));
        tbl.push_back(mk(1, 1, 1, 8'h0F, 0, CkTone0, 'h0FE, CkAtten0, 15));
        tbl.push_back(mk(1, 1, 1, 8'hBF, 0, CkAtten1, 15, CkTone1, 0));
        tbl.push_back(mk(1, 1, 1, 8'hB5, 0, CkAtten1, 5, CkNone, 0));
        tbl.push_back(mk(1, 1, 1, 8'h03, 0, CkAtten1, 3, CkTone1, 0));
        tbl.push_back(mk(1, 1, 1, 8'hE5, 0, CkNoise, 5, CkNr, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, CkNr, 0, CkNoise, 5));
        tbl.push_back(mk(1, 1, 1, 8'h06, 0, CkNoise, 6, CkNr, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, CkNr, 0, CkNoise, 6));

        foreach (tbl[i]) begin
            if (tbl[i].wr) wait_ready();
            step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].e);
            if (tbl[i].ca != CkNone) check_fixed(i, tbl[i].ca, tbl[i].ea);
            if (tbl[i].cb != CkNone) check_fixed(i, tbl[i].cb, tbl[i].eb);
        end

`ifdef PSG_READY_EN
        // Busy window: writes ignored until the second tick, including the exit cycle.
        wait_ready();
        step(1, 1, 8'hC3, 0);
        check("busy_write_tone2", 32'(tone2_freq), 32'h003);
        check("busy_ready_low", 32'(ready), 32'd0);
        step(1, 1, 8'h01, 0);
        check("busy_drop_tone2", 32'(tone2_freq), 32'h003);
        step(1, 1, 8'h01, 1);
        check("busy_after_tick1", 32'(ready), 32'd0);
        step(1, 1, 8'h01, 1);
        check("busy_exit_drop", 32'(tone2_freq), 32'h003);
        check("busy_exit_ready", 32'(ready), 32'd1);
        step(1, 1, 8'h01, 0);
        check("post_busy_accept", 32'(tone2_freq), 32'h013);
        // A tick on the accepting edge is not counted.
        wait_ready();
        step(1, 1, 8'hC5, 1);
        step(1, 0, 8'h00, 1);
        check("coincident_tick", 32'(ready), 32'd0);
        step(1, 0, 8'h00, 1);
        check("coincident_exit", 32'(ready), 32'd1);
        // Reset aborts the busy window and beats a simultaneous write.
        step(1, 1, 8'h8A, 0);
        check("pre_reset_tone0", 32'(tone0_freq), 32'h0FA);
        step(0, 1, 8'h81, 0);
        check("reset_tone0", 32'(tone0_freq), 32'h000);
        check("reset_ready", 32'(ready), 32'd1);
        step(1, 1, 8'h81, 0);
        check("after_reset_write", 32'(tone0_freq), 32'h001);
`else
        step(1, 1, 8'h81, 0);
        check("b2b_first", 32'(tone0_freq), 32'h0F1);
        step(1, 1, 8'h3F, 0);
        check("b2b_second", 32'(tone0_freq), 32'h3F1);
        check("b2b_ready", 32'(ready), 32'd1);
        step(0, 1, 8'h8A, 0);
        check("reset_tone0", 32'(tone0_freq), 32'h000);
        step(1, 1, 8'h81, 0);
        check("after_reset_write", 32'(tone0_freq), 32'h001);
`endif

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)),
                 8'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psg_register_decoder.md
PSG_REGISTER_DECODER -- requirements
Module: psg_register_decoder

Interface
REQ-001 Parameter: BUSY_TICKS, default 2, number of clk_div16_en pulses that ready stays low after an accepted write; legal range 0..15.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 clk_div16_en  input  1  one-clk-wide enable at clk/16; times the busy window.
REQ-005 we  input  1  write strobe, active-high, sampled each clk.
REQ-006 din  input  8  write data byte.
REQ-007 ready  output  1  high = next write will be accepted.
REQ-008 tone0_freq, tone1_freq, tone2_freq  output  10 each  tone period registers.
REQ-009 noise_ctrl  output  3  noise register: bit2 = feedback/mode, bits1:0 = rate.
REQ-010 atten0..atten3  output  4 each  attenuation registers; 4'hF = silent.
REQ-011 noise_reset  output  1  one-clk pulse on each noise register write.

Function
REQ-012 A write is accepted when we=1 and ready=1 on the same clk edge; we while ready=0 is discarded with no state change.
REQ-013 Latch byte (din[7]=1): latched channel <= din[6:5], latched type <= din[4] (1 = attenuation, 0 = tone/noise); selected register updated with din[3:0].
REQ-014 Latch byte to a tone channel (0..2, type 0): freq[3:0] <= din[3:0]; freq[9:4] unchanged.
REQ-015 Data byte (din[7]=0) to a latched tone channel: freq[9:4] <= din[5:0]; freq[3:0] unchanged; din[6] ignored.
REQ-016 Latch or data byte targeting attenuation: atten[ch] <= din[3:0].
REQ-017 Latch or data byte targeting channel 3 type 0: noise_ctrl <= din[2:0]; din[3] ignored; noise_reset high for exactly the following clk.
REQ-018 Data bytes never change the latched channel/type; consecutive data bytes all go to the same register.
REQ-019 Register outputs and noise_reset change on the clk edge that accepts the write (visible one cycle after we is presented); all outputs are registered.
REQ-020 Busy FSM, two states: IDLE (ready=1), BUSY (ready=0).
REQ-021 IDLE -> BUSY on accepted write when BUSY_TICKS>0; 4-bit counter loads BUSY_TICKS.
REQ-022 In BUSY, counter decrements on each clk_div16_en; when counter=1 and clk_div16_en=1 -> IDLE, ready=1 from next cycle.
REQ-023 clk_div16_en coincident with the accepting edge is not counted.
REQ-024 BUSY_TICKS=0: FSM stays in IDLE, ready constantly 1, back-to-back writes on consecutive clks all accepted.
REQ-025 we asserted on the cycle BUSY exits (ready still 0) is discarded.

Reset
REQ-026 reset=0 at a clk edge: tone*_freq=0, atten*=4'hF, noise_ctrl=0, noise_reset=0, latched channel=0/type=0, FSM=IDLE, counter=0, ready=1.
REQ-027 reset mid-BUSY aborts the window; ready=1 on the cycle after reset deasserts; reset has priority over a simultaneous we.

Configuration
REQ-028 Macro PSG_READY_EN defined: ready handshake and busy FSM per REQ-020..REQ-025.
REQ-029 PSG_READY_EN undefined: busy FSM and counter omitted, ready tied to 1, every we accepted, BUSY_TICKS ignored; decode behaviour unchanged.

Verification
REQ-030 After reset: we din=8'h8E then din=8'h0F (BUSY_TICKS=0) -> tone0_freq=10'h0FE, atten0=4'hF, ready=1 throughout.
REQ-031 we din=8'hBF -> atten1=4'hF; then din=8'hB5 -> atten1=4'h5; then data byte 8'h03 -> atten1=4'h3, tone1_freq unchanged.
REQ-032 we din=8'hE5 -> noise_ctrl=3'b101, noise_reset high exactly 1 clk; data byte 8'h06 -> noise_ctrl=3'b110, second 1-clk pulse.
REQ-033 PSG_READY_EN, BUSY_TICKS=2: write 8'hC3 -> ready low the next cycle; writes 8'h01 during BUSY ignored (tone2_freq stays 10'h003); ready high after 2nd clk_div16_en.
REQ-034 Assert reset during BUSY after write 8'h8A -> tone0_freq=0, ready=1 after reset release; next write 8'h81 accepted.
REQ-035 PSG_READY_EN undefined: writes 8'h81, 8'h3F on consecutive clks -> tone0_freq=10'h3F1, ready constantly 1.
